// File: rtl/comb_resp_checker.sv
// comb_resp_checker
//   Self-checking response sink for combinational stimulus runs. Each accepted
//   vector carries the DUT output (y_in) and the golden bit (exp_y). The block
//   counts mismatches, latches the first failing vector, and compacts every DUT
//   output into a 16-bit MISR signature.
//
//   Optional build macro: CHK_XPROP_EN. When it is defined, X/Z on y_in counts
//   as a mismatch, feeds the MISR as a 1, and raises the extra output x_seen.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   start                 begin a run (honoured in IDLE or DONE only)
//   vec_valid/vec_ready   vector handshake
//   vec_in, y_in, exp_y   stimulus vector, DUT output, golden output
//   busy, done            run in progress / run complete (results stable)
//   err_cnt               saturating mismatch count
//   first_err_vld/_vec    first mismatching vector of the run
//   vec_cnt               vectors accepted this run
//   signature             MISR value
//   x_seen                (CHK_XPROP_EN only) an X/Z y_in was accepted
//
// state   | meaning
// IDLE    | after reset, no run started yet
// CAPTURE | run active, accepting vectors
// DONE    | NVEC vectors taken, results held until start or rst

module comb_resp_checker #(
    parameter int          IN_W = 4,
    parameter int          NVEC = 16,
    parameter logic [15:0] POLY = 16'h1021,
    parameter logic [15:0] SEED = 16'hFFFF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            vec_valid,
    output logic            vec_ready,
    input  logic [IN_W-1:0] vec_in,
    input  logic            y_in,
    input  logic            exp_y,
    output logic            busy,
    output logic            done,
    output logic [15:0]     err_cnt,
    output logic            first_err_vld,
    output logic [IN_W-1:0] first_err_vec,
    output logic [15:0]     vec_cnt,
    output logic [15:0]     signature
`ifdef CHK_XPROP_EN
    ,
    output logic            x_seen
`endif
);

    if (NVEC < 1 || NVEC > 65535) begin : g_nvec_chk
        $error("comb_resp_checker: NVEC must be in 1..65535");
    end

    localparam logic [15:0] LAST_CNT = 16'(NVEC - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic accept;
    logic start_run;
    logic last_accept;
    logic mismatch;
    logic y_fb;
    logic fb;

    assign vec_ready   = (state == S_CAPTURE);
    assign busy        = (state == S_CAPTURE);
    assign done        = (state == S_DONE);
    assign accept      = vec_valid & vec_ready;
    // start is ignored while a run is active: no restart, no clear.
    assign start_run   = start & (state != S_CAPTURE);
    assign last_accept = accept & (vec_cnt == LAST_CNT);

`ifdef CHK_XPROP_EN
    logic y_xz;
    assign y_xz     = (y_in !== 1'b0) && (y_in !== 1'b1);
    assign mismatch = (y_in !== exp_y);
    // Unknown DUT output is folded into the signature as a 1.
    assign y_fb     = (y_in === 1'b0) ? 1'b0 : 1'b1;
`else
    assign mismatch = (y_in != exp_y);
    assign y_fb     = y_in;
`endif

    assign fb = signature[15] ^ y_fb;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start)       state_nxt = S_CAPTURE;
            S_CAPTURE: if (last_accept) state_nxt = S_DONE;
            S_DONE:    if (start)       state_nxt = S_CAPTURE;
            default:                    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || start_run) begin
            err_cnt       <= 16'h0;
            vec_cnt       <= 16'h0;
            first_err_vld <= 1'b0;
            first_err_vec <= '0;
            signature     <= SEED;
        end else if (accept) begin
            vec_cnt <= vec_cnt + 16'h1;
            if (mismatch && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'h1;
            end
            if (mismatch && !first_err_vld) begin
                first_err_vld <= 1'b1;
                first_err_vec <= vec_in;
            end
            signature <= {signature[14:0], 1'b0} ^ (fb ? POLY : 16'h0);
        end
    end

`ifdef CHK_XPROP_EN
    always_ff @(posedge clk) begin
        if (rst || start_run) begin
            x_seen <= 1'b0;
        end else if (accept && y_xz) begin
            x_seen <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_comb_resp_checker.sv
// Testbench for comb_resp_checker: randomized and directed runs on an NVEC=16
// instance with a run-level scoreboard, plus a single-vector run on an NVEC=1
// instance.
module tb_comb_resp_checker;

    localparam int          NVEC = 16;
    localparam logic [15:0] POLY = 16'h1021;
    localparam logic [15:0] SEED = 16'hFFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        start = 1'b0, vec_valid = 1'b0, y_in = 1'b0, exp_y = 1'b0;
    logic [3:0]  vec_in = 4'h0;
    logic        vec_ready, busy, done, first_err_vld;
    logic [3:0]  first_err_vec;
    logic [15:0] err_cnt, vec_cnt, signature;

    logic        start1 = 1'b0, vec_valid1 = 1'b0, y_in1 = 1'b0, exp_y1 = 1'b0;
    logic [3:0]  vec_in1 = 4'h0;
    logic        vec_ready1, busy1, done1, first_err_vld1;
    logic [3:0]  first_err_vec1;
    logic [15:0] err_cnt1, vec_cnt1, signature1;

`ifdef CHK_XPROP_EN
    logic x_seen, x_seen1;
`endif

    comb_resp_checker #(.IN_W(4), .NVEC(NVEC), .POLY(POLY), .SEED(SEED)) u_dut (
        .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid), .vec_ready(vec_ready),
        .vec_in(vec_in), .y_in(y_in), .exp_y(exp_y), .busy(busy), .done(done),
        .err_cnt(err_cnt), .first_err_vld(first_err_vld), .first_err_vec(first_err_vec),
        .vec_cnt(vec_cnt), .signature(signature)
`ifdef CHK_XPROP_EN
        , .x_seen(x_seen)
`endif
    );

    comb_resp_checker #(.IN_W(4), .NVEC(1), .POLY(POLY), .SEED(SEED)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .vec_valid(vec_valid1), .vec_ready(vec_ready1),
        .vec_in(vec_in1), .y_in(y_in1), .exp_y(exp_y1), .busy(busy1), .done(done1),
        .err_cnt(err_cnt1), .first_err_vld(first_err_vld1), .first_err_vec(first_err_vec1),
        .vec_cnt(vec_cnt1), .signature(signature1)
`ifdef CHK_XPROP_EN
        , .x_seen(x_seen1)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] err;
        logic [15:0] cnt;
        logic [15:0] sig;
        logic        fvld;
        logic [3:0]  fvec;
    } res_t;

    res_t exp_q[$];

    // Reference model: a record of accepted vectors for the current run.
    bit         m_ready = 1'b0;
    logic [3:0] m_vec[$];
    bit         m_y[$];
    bit         m_e[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic res_t model_result();
        res_t r;
        logic [15:0] s;
        s      = SEED;
        r.err  = 16'h0;
        r.fvld = 1'b0;
        r.fvec = 4'h0;
        for (int i = 0; i < m_y.size(); i++) begin
            // Signature is the MISR image of the DUT output stream.
            s = {s[14:0], 1'b0} ^ ((s[15] ^ m_y[i]) ? POLY : 16'h0);
            if (m_y[i] != m_e[i]) begin
                if (r.err != 16'hFFFF) r.err++;
                if (!r.fvld) begin
                    r.fvld = 1'b1;
                    r.fvec = m_vec[i];
                end
            end
        end
        r.cnt = 16'(m_y.size());
        r.sig = s;
        return r;
    endfunction

    task automatic model_clear();
        m_vec.delete();
        m_y.delete();
        m_e.delete();
    endtask

    // One clock of stimulus: inputs driven on the falling edge, sampled by the DUT
    // at the following rising edge.
    task automatic cycle(bit st, bit v, logic [3:0] vec, bit y, bit e);
        @(negedge clk);
        chk("vec_ready", {31'h0, vec_ready}, {31'h0, m_ready});
        chk("busy", {31'h0, busy}, {31'h0, m_ready});
        start = st; vec_valid = v; vec_in = vec; y_in = y; exp_y = e;
        if (m_ready && v) begin
            m_vec.push_back(vec);
            m_y.push_back(y);
            m_e.push_back(e);
            if (m_y.size() == NVEC) begin
                exp_q.push_back(model_result());
                m_ready = 1'b0;
            end
        end else if (!m_ready && st) begin
            model_clear();
            m_ready = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0; vec_valid = 1'b0;
        m_ready = 1'b0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        chk("rst busy", {31'h0, busy}, 32'h0);
        chk("rst done", {31'h0, done}, 32'h0);
        chk("rst vec_ready", {31'h0, vec_ready}, 32'h0);
        chk("rst err_cnt", {16'h0, err_cnt}, 32'h0);
        chk("rst vec_cnt", {16'h0, vec_cnt}, 32'h0);
        chk("rst first_err_vld", {31'h0, first_err_vld}, 32'h0);
        chk("rst first_err_vec", {28'h0, first_err_vec}, 32'h0);
        chk("rst signature", {16'h0, signature}, {16'h0, SEED});
        rst = 1'b0;
    endtask

    // mode 0: random, 1: directed vec=index with mismatches at 5 and 9,
    // 2: valid toggling plus a start pulse mid-run, 3: clean run (no mismatches).
    task automatic run(int mode);
        bit         v, y, e, st;
        logic [3:0] vec;
        int         k;
        cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        k = 0;
        while (m_ready && k < 300) begin
            st  = 1'b0;
            y   = 1'($urandom_range(0, 1));
            vec = 4'($urandom_range(0, 15));
            case (mode)
                1: begin
                    v   = 1'b1;
                    vec = 4'(m_y.size());
                    e   = (m_y.size() == 5 || m_y.size() == 9) ? ~y : y;
                end
                2: begin
                    v  = (k % 2) == 1;
                    st = (k == 11);
                    e  = ($urandom_range(0, 3) == 0) ? ~y : y;
                end
                3: begin
                    v = ($urandom_range(0, 3) != 0);
                    e = y;
                end
                default: begin
                    v = ($urandom_range(0, 3) != 0);
                    e = ($urandom_range(0, 4) == 0) ? ~y : y;
                end
            endcase
            cycle(st, v, vec, y, e);
            k++;
        end
        if (m_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL run_timeout: mode %0d accepted %0d vectors, required %0d", mode, m_y.size(), NVEC);
        end
        repeat (3) cycle(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    // Monitor: compares results whenever the DUT raises done.
    logic done_d = 1'b0;
    res_t r_exp;
    always @(negedge clk) begin
        if (done && !done_d) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: done rose with no expected run result");
            end else begin
                r_exp = exp_q.pop_front();
                chk("done err_cnt", {16'h0, err_cnt}, {16'h0, r_exp.err});
                chk("done vec_cnt", {16'h0, vec_cnt}, {16'h0, r_exp.cnt});
                chk("done signature", {16'h0, signature}, {16'h0, r_exp.sig});
                chk("done first_err_vld", {31'h0, first_err_vld}, {31'h0, r_exp.fvld});
                chk("done first_err_vec", {28'h0, first_err_vec}, {28'h0, r_exp.fvec});
            end
        end
        done_d = rst ? 1'b0 : done;
    end

    initial begin
        do_reset();

        // Single-vector run on the NVEC=1 instance.
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("n1 vec_ready", {31'h0, vec_ready1}, 32'h1);
        vec_valid1 = 1'b1; vec_in1 = 4'hA; y_in1 = 1'b0; exp_y1 = 1'b0;
        @(negedge clk);
        vec_valid1 = 1'b0;
        chk("n1 done", {31'h0, done1}, 32'h1);
        chk("n1 busy", {31'h0, busy1}, 32'h0);
        chk("n1 vec_ready off", {31'h0, vec_ready1}, 32'h0);
        chk("n1 err_cnt", {16'h0, err_cnt1}, 32'h0);
        chk("n1 vec_cnt", {16'h0, vec_cnt1}, 32'h1);
        chk("n1 signature", {16'h0, signature1}, 32'h0000EFDF);
        chk("n1 first_err_vld", {31'h0, first_err_vld1}, 32'h0);
        chk("n1 first_err_vec", {28'h0, first_err_vec1}, 32'h0);

        run(1);
        chk("dir first_err_vec", {28'h0, first_err_vec}, 32'h5);
        chk("dir err_cnt", {16'h0, err_cnt}, 32'h2);
        chk("dir done held", {31'h0, done}, 32'h1);

        run(2);
        chk("toggle vec_cnt", {16'h0, vec_cnt}, 32'h10);

        for (int i = 0; i < 5; i++) run(0);

        // Abort a run after 7 accepts.
        cycle(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        while (m_y.size() < 7) cycle(1'b0, 1'b1, 4'(m_y.size()), 1'b1, 1'b0);
        do_reset();
        run(3);
        chk("clean err_cnt", {16'h0, err_cnt}, 32'h0);

        repeat (3) @(negedge clk);
        chk("scoreboard drained", exp_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
